// File: rtl/pelican_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pelican_pkg
//  Description : Shared types and lamp encodings for the pelican crossing
//                controller. Holds the FSM state enum and the lamp decode
//                helpers that map a state and flash phase onto the two heads.
//  Contents    : state_t, traffic/pedestrian lamp constants,
//                traffic_decode(), ped_decode()
//  Revision    : 1.0 - initial release
// ============================================================================
package pelican_pkg;

    typedef enum logic [2:0] {
        RED       = 3'd0,
        RED_AMBER = 3'd1,
        GREEN     = 3'd2,
        AMBER     = 3'd3,
        ALL_RED   = 3'd4,
        WALK      = 3'd5,
        FLASH     = 3'd6
    } state_t;

    // Traffic head: [2]=red, [1]=amber, [0]=green
    localparam logic [2:0] TL_RED       = 3'b100;
    localparam logic [2:0] TL_RED_AMBER = 3'b110;
    localparam logic [2:0] TL_GREEN     = 3'b001;
    localparam logic [2:0] TL_AMBER     = 3'b010;

    // Pedestrian head: [1]=red, [0]=green
    localparam logic [1:0] PED_STOP = 2'b10;
    localparam logic [1:0] PED_WALK = 2'b01;

    // In FLASH the amber and pedestrian green blink together, so both heads
    // depend on the flash phase as well as the state.
    function automatic logic [2:0] traffic_decode(input state_t s, input logic ph);
        logic [2:0] tl;
        case (s)
            RED_AMBER: tl = TL_RED_AMBER;
            GREEN:     tl = TL_GREEN;
            AMBER:     tl = TL_AMBER;
            FLASH:     tl = {1'b0, ph, 1'b0};
            default:   tl = TL_RED;
        endcase
        return tl;
    endfunction

    function automatic logic [1:0] ped_decode(input state_t s, input logic ph);
        logic [1:0] pl;
        case (s)
            WALK:    pl = PED_WALK;
            FLASH:   pl = {~ph, ph};
            default: pl = PED_STOP;
        endcase
        return pl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pelican_crossing_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pelican_crossing_ctrl_if
//  Description : Board-side signal bundle of the pelican crossing controller.
//  Ports       : button            - raw pedestrian button (async, active high)
//                traffic_lights    - [2]=red [1]=amber [0]=green
//                pedestrian_lights - [1]=red [0]=green
//                wait_lamp         - request acknowledged
//                state             - current FSM state (debug)
//  Modports    : master - the controller; slave - the board / lamp drivers
//  Revision    : 1.0 - initial release
// ============================================================================
interface pelican_crossing_ctrl_if;
    import pelican_pkg::*;

    logic       button;
    logic [2:0] traffic_lights;
    logic [1:0] pedestrian_lights;
    logic       wait_lamp;
    state_t     state;

    modport master (
        input  button,
        output traffic_lights,
        output pedestrian_lights,
        output wait_lamp,
        output state
    );

    modport slave (
        output button,
        input  traffic_lights,
        input  pedestrian_lights,
        input  wait_lamp,
        input  state
    );

endinterface
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dwell_timer
//  Description : Millisecond prescaler plus ms counter used to time each
//                phase of the crossing. restart clears both on state entry.
//  Ports       : clk     - system clock
//                nrst    - asynchronous active-low reset
//                restart - synchronous clear of prescaler and ms counter
//                tick    - high for one cycle every CLK_PER_MS cycles
//                ms_cnt  - whole milliseconds elapsed since last restart
//  Revision    : 1.0 - initial release
// ============================================================================
module dwell_timer #(
    parameter int CLK_PER_MS = 1,
    parameter int MS_W       = 16
) (
    input  wire logic            clk,
    input  wire logic            nrst,
    input  wire logic            restart,
    output logic                 tick,
    output logic [MS_W-1:0]      ms_cnt
);

    // A 1-cycle ms still needs a 1-bit prescaler; it just never leaves 0,
    // which keeps tick permanently high.
    localparam int              PRE_W    = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_MS - 1);

    logic [PRE_W-1:0] r_pre;
    logic [MS_W-1:0]  r_ms;
    logic             w_tick;

    assign w_tick = (r_pre == PRE_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_pre <= '0;
            r_ms  <= '0;
        end else if (restart) begin
            r_pre <= '0;
            r_ms  <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
            r_ms  <= r_ms + MS_W'(1);
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    assign tick   = w_tick;
    assign ms_cnt = r_ms;

endmodule
`default_nettype wire

// File: rtl/pelican_crossing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pelican_crossing_ctrl
//  Description : Pelican crossing controller. One traffic head, one
//                pedestrian head, one push button. Timed phases with a
//                minimum-green guarantee, all-red clearance before walk and a
//                flashing phase after walk.
//  Ports       : clk  - system clock
//                nrst - asynchronous active-low reset
//                bus  - pelican_crossing_ctrl_if.master (button, lamps,
//                       wait_lamp, state)
//  Revision    : 1.0 - initial release
// ============================================================================
module pelican_crossing_ctrl
    import pelican_pkg::*;
#(
    parameter int CLK_PER_MS     = 1,
    parameter int MS_W           = 16,
    parameter int T_RED_MS       = 30000,
    parameter int T_RED_AMBER_MS = 3000,
    parameter int T_MIN_GREEN_MS = 10000,
    parameter int T_GREEN_MS     = 30000,
    parameter int T_AMBER_MS     = 3000,
    parameter int T_CLEAR_MS     = 2000,
    parameter int T_WALK_MS      = 20000,
    parameter int T_FLASH_MS     = 6000,
    parameter int FLASH_HALF_MS  = 500
) (
    input  wire logic                 clk,
    input  wire logic                 nrst,
    pelican_crossing_ctrl_if.master   bus
);

    // Last ms count of each phase: the exit happens on the tick that would
    // take the counter past this value.
    localparam logic [MS_W-1:0] RED_LAST       = MS_W'(T_RED_MS - 1);
    localparam logic [MS_W-1:0] RED_AMBER_LAST = MS_W'(T_RED_AMBER_MS - 1);
    localparam logic [MS_W-1:0] GREEN_LAST     = MS_W'(T_GREEN_MS - 1);
    localparam logic [MS_W-1:0] AMBER_LAST     = MS_W'(T_AMBER_MS - 1);
    localparam logic [MS_W-1:0] CLEAR_LAST     = MS_W'(T_CLEAR_MS - 1);
    localparam logic [MS_W-1:0] WALK_LAST      = MS_W'(T_WALK_MS - 1);
    localparam logic [MS_W-1:0] FLASH_LAST     = MS_W'(T_FLASH_MS - 1);
    localparam logic [MS_W-1:0] HALF_LAST      = MS_W'(FLASH_HALF_MS - 1);
    localparam logic [MS_W:0]   MIN_GREEN      = (MS_W+1)'(T_MIN_GREEN_MS);

    state_t          r_state;
    state_t          w_next;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_btn_prev;
    logic            r_req;
    logic            r_ph;
    logic            w_ph_next;
    logic [MS_W-1:0] r_half;
    logic [MS_W-1:0] w_half_next;
    logic [2:0]      r_tl;
    logic [1:0]      r_pl;

    logic            w_tick;
    logic [MS_W-1:0] w_ms;
    logic [MS_W:0]   w_ms_plus1;
    logic            w_restart;
    logic            w_btn_edge;

    dwell_timer #(
        .CLK_PER_MS (CLK_PER_MS),
        .MS_W       (MS_W)
    ) u_dwell_timer (
        .clk     (clk),
        .nrst    (nrst),
        .restart (w_restart),
        .tick    (w_tick),
        .ms_cnt  (w_ms)
    );

    assign w_btn_edge = r_sync2 & ~r_btn_prev;
    assign w_ms_plus1 = {1'b0, w_ms} + (MS_W+1)'(1);

    // Next-state decode. Only the registered request is consulted, so a
    // press never reaches the lamps without passing through r_req first.
    always_comb begin
        w_next = r_state;
        case (r_state)
            RED: begin
                if (w_tick && r_req)
                    w_next = WALK;
                else if (w_tick && (w_ms == RED_LAST))
                    w_next = RED_AMBER;
            end
            RED_AMBER: if (w_tick && (w_ms == RED_AMBER_LAST)) w_next = GREEN;
            GREEN: begin
                if (w_tick && ((r_req && (w_ms_plus1 >= MIN_GREEN)) || (w_ms == GREEN_LAST)))
                    w_next = AMBER;
            end
            AMBER:   if (w_tick && (w_ms == AMBER_LAST)) w_next = r_req ? ALL_RED : RED;
            ALL_RED: if (w_tick && (w_ms == CLEAR_LAST)) w_next = WALK;
            WALK:    if (w_tick && (w_ms == WALK_LAST))  w_next = FLASH;
            FLASH:   if (w_tick && (w_ms == FLASH_LAST)) w_next = RED_AMBER;
            default: w_next = RED;
        endcase
    end

    // Every transition moves to a different state, so a change of state is
    // exactly the state-entry event that restarts the timers.
    assign w_restart = (w_next != r_state);

    // Flash phase starts lit on every entry and toggles each FLASH_HALF_MS.
    always_comb begin
        w_ph_next   = r_ph;
        w_half_next = r_half;
        if (w_restart) begin
            w_ph_next   = 1'b1;
            w_half_next = '0;
        end else if ((r_state == FLASH) && w_tick) begin
            if (r_half == HALF_LAST) begin
                w_ph_next   = ~r_ph;
                w_half_next = '0;
            end else begin
                w_half_next = r_half + MS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_btn_prev <= 1'b0;
            r_req      <= 1'b0;
            r_state    <= RED;
            r_ph       <= 1'b1;
            r_half     <= '0;
            r_tl       <= TL_RED;
            r_pl       <= PED_STOP;
        end else begin
            r_sync1    <= bus.button;
            r_sync2    <= r_sync1;
            r_btn_prev <= r_sync2;

            // Entering WALK serves the request; that clear beats a new edge.
            if ((w_next == WALK) && (r_state != WALK))
                r_req <= 1'b0;
            else if (w_btn_edge && (r_state != WALK) && (r_state != FLASH))
                r_req <= 1'b1;

            r_state <= w_next;
            r_ph    <= w_ph_next;
            r_half  <= w_half_next;
            // Lamps are decoded from the next state so they switch on the
            // same edge as the state register.
            r_tl    <= traffic_decode(w_next, w_ph_next);
            r_pl    <= ped_decode(w_next, w_ph_next);
        end
    end

    assign bus.traffic_lights    = r_tl;
    assign bus.pedestrian_lights = r_pl;
    assign bus.wait_lamp         = r_req;
    assign bus.state             = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pelican_crossing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pelican_crossing_ctrl
//  Description : Directed self-checking bench for pelican_crossing_ctrl with
//                short dwell times (4 clocks per ms).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pelican_crossing_ctrl;
    import pelican_pkg::*;

    logic clk;
    logic nrst;
    int   n_vec;
    int   n_err;

    pelican_crossing_ctrl_if sig ();

    pelican_crossing_ctrl #(
        .CLK_PER_MS     (4),
        .MS_W           (8),
        .T_RED_MS       (10),
        .T_RED_AMBER_MS (3),
        .T_MIN_GREEN_MS (4),
        .T_GREEN_MS     (10),
        .T_AMBER_MS     (3),
        .T_CLEAR_MS     (2),
        .T_WALK_MS      (5),
        .T_FLASH_MS     (4),
        .FLASH_HALF_MS  (1)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges; sample point is 1 ns after each rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Count edges until the state leaves st; 'already' edges of the phase
    // have elapsed when called.
    task automatic dwell(input string tag, input state_t st, input int exp_n, input int already);
        int n;
        n = already;
        while ((sig.state == st) && (n < exp_n + 50)) begin
            step(1);
            n++;
        end
        check_vec(tag, n, exp_n);
    endtask

    task automatic wait_state(input string tag, input state_t st, input int limit);
        int n;
        n = 0;
        while ((sig.state != st) && (n < limit)) begin
            step(1);
            n++;
        end
        check_vec(tag, sig.state, st);
    endtask

    task automatic check_lamps(input string tag, input logic [2:0] tl, input logic [1:0] pl);
        check_vec({tag, " traffic"}, sig.traffic_lights, tl);
        check_vec({tag, " ped"}, sig.pedestrian_lights, pl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int     walk_cnt;
        state_t prev;
        n_vec      = 0;
        n_err      = 0;
        sig.button = 1'b0;
        nrst       = 1'b1;
        #2 nrst    = 1'b0;

        // ---- Reset state ----
        step(3);
        check_vec("rst state", sig.state, RED);
        check_lamps("rst", 3'b100, 2'b10);
        check_vec("rst wait", sig.wait_lamp, 1'b0);
        #2 nrst = 1'b1;

        // ---- 1: free-running cycle, no button ----
        check_lamps("s1 red", 3'b100, 2'b10);
        dwell("s1 red dwell", RED, 40, 0);
        check_lamps("s1 red_amber", 3'b110, 2'b10);
        dwell("s1 red_amber dwell", RED_AMBER, 12, 0);
        check_lamps("s1 green", 3'b001, 2'b10);
        dwell("s1 green dwell", GREEN, 40, 0);
        check_lamps("s1 amber", 3'b010, 2'b10);
        dwell("s1 amber dwell", AMBER, 12, 0);
        check_vec("s1 back to red", sig.state, RED);

        // ---- 2: press early in GREEN, min-green exit ----
        dwell("s2 red dwell", RED, 40, 0);
        dwell("s2 red_amber dwell", RED_AMBER, 12, 0);
        step(2);
        sig.button = 1'b1;
        step(2);
        check_vec("s2 wait before", sig.wait_lamp, 1'b0);
        step(1);
        check_vec("s2 wait after", sig.wait_lamp, 1'b1);
        sig.button = 1'b0;
        dwell("s2 green min dwell", GREEN, 16, 5);
        dwell("s2 amber dwell", AMBER, 12, 0);
        check_vec("s2 all_red", sig.state, ALL_RED);
        check_lamps("s2 all_red", 3'b100, 2'b10);
        dwell("s2 all_red dwell", ALL_RED, 8, 0);
        check_vec("s2 walk", sig.state, WALK);
        check_lamps("s2 walk", 3'b100, 2'b01);
        check_vec("s2 walk wait", sig.wait_lamp, 1'b0);
        dwell("s2 walk dwell", WALK, 20, 0);
        for (int i = 0; i < 4; i++) begin
            check_vec("s2 flash state", sig.state, FLASH);
            if ((i % 2) == 0)
                check_lamps("s2 flash on", 3'b010, 2'b01);
            else
                check_lamps("s2 flash off", 3'b000, 2'b10);
            step(4);
        end
        check_vec("s2 after flash", sig.state, RED_AMBER);
        dwell("s2 red_amber dwell", RED_AMBER, 12, 0);
        dwell("s2 green full dwell", GREEN, 40, 0);
        dwell("s2 amber2 dwell", AMBER, 12, 0);

        // ---- 3: press mid-RED, press during WALK ignored ----
        check_vec("s3 red", sig.state, RED);
        step(13);
        sig.button = 1'b1;
        step(2);
        check_vec("s3 wait before", sig.wait_lamp, 1'b0);
        step(1);
        check_vec("s3 wait after", sig.wait_lamp, 1'b1);
        sig.button = 1'b0;
        dwell("s3 red to walk", RED, 20, 16);
        check_vec("s3 walk", sig.state, WALK);
        step(3);
        sig.button = 1'b1;
        step(3);
        sig.button = 1'b0;
        step(2);
        check_vec("s3 walk press ignored", sig.wait_lamp, 1'b0);
        dwell("s3 walk dwell", WALK, 20, 8);
        dwell("s3 flash dwell", FLASH, 16, 0);
        dwell("s3 red_amber dwell", RED_AMBER, 12, 0);
        dwell("s3 green no req", GREEN, 40, 0);
        dwell("s3 amber dwell", AMBER, 12, 0);

        // ---- 4: button held 200 cycles -> one request ----
        check_vec("s4 red", sig.state, RED);
        sig.button = 1'b1;
        walk_cnt   = 0;
        prev       = RED;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if ((sig.state == WALK) && (prev != WALK))
                walk_cnt++;
            prev = sig.state;
        end
        sig.button = 1'b0;
        check_vec("s4 walk count", walk_cnt, 1);
        check_vec("s4 state at 200", sig.state, AMBER);
        check_vec("s4 no pending", sig.wait_lamp, 1'b0);
        wait_state("s4 red", RED, 100);

        // ---- 5: asynchronous reset mid-WALK ----
        sig.button = 1'b1;
        step(3);
        sig.button = 1'b0;
        wait_state("s5 walk", WALK, 20);
        step(5);
        #2 nrst = 1'b0;
        #1;
        check_vec("s5 rst state", sig.state, RED);
        check_lamps("s5 rst", 3'b100, 2'b10);
        check_vec("s5 rst wait", sig.wait_lamp, 1'b0);
        step(2);
        #2 nrst = 1'b1;
        dwell("s5 red after rst", RED, 40, 0);

        // ---- 6: press lands on GREEN max-timeout edge ----
        dwell("s6 red_amber dwell", RED_AMBER, 12, 0);
        step(37);
        sig.button = 1'b1;
        step(2);
        check_vec("s6 green at 39", sig.state, GREEN);
        check_vec("s6 wait at 39", sig.wait_lamp, 1'b0);
        step(1);
        check_vec("s6 amber at 40", sig.state, AMBER);
        check_vec("s6 wait at 40", sig.wait_lamp, 1'b1);
        sig.button = 1'b0;
        dwell("s6 amber dwell", AMBER, 12, 0);
        check_vec("s6 all_red", sig.state, ALL_RED);
        dwell("s6 all_red dwell", ALL_RED, 8, 0);
        check_vec("s6 walk", sig.state, WALK);
        check_vec("s6 walk wait", sig.wait_lamp, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
